// File: rtl/imem_fetch_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states, widths and the
// {pc, inst} entry carried through the fetch buffer.
package imem_fetch_pkg;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Word-aligned and no later than the last full word of memory.
    function automatic logic pc_legal(input logic [PC_W-1:0] pc,
                                      input logic [PC_W-1:0] last_pc);
        return (pc[1:0] == 2'b00) && (pc <= last_pc);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, inst} entries; flush beats push.
module fetch_buffer
    import imem_fetch_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    fetch_entry_t mem_q [BUF_DEPTH];
    logic         do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: PC, BOOT/RUN/HALT control, redirect/range checks, fetch buffer.
// Optional FETCH_BYPASS_EN forwards the current fetch straight to decode when the buffer is empty.
module inst_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 64'h0,
    parameter int unsigned     MEM_BYTES = 132,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [PC_W-1:0]   inst_addr,
    input  logic [INST_W-1:0] inst_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic              fault
);

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(MEM_BYTES) - PC_W'(4);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;

    logic            buf_push, buf_pop, buf_flush, buf_full, buf_empty;
    fetch_entry_t    buf_head, fetch_word;
    logic            bypass, can_fetch, redirect_ok;

    assign fetch_word.pc   = pc_q;
    assign fetch_word.inst = inst_data;
    assign redirect_ok     = pc_legal(redirect_pc, LAST_PC);

`ifdef FETCH_BYPASS_EN
    assign bypass = (state_q == RUN) && buf_empty && !redirect_valid && !halt_req &&
                    (pc_q <= LAST_PC);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        out_valid = !buf_empty;
        out_pc    = buf_empty ? '0 : buf_head.pc;
        out_inst  = buf_empty ? '0 : buf_head.inst;
        if (bypass) begin
            out_valid = 1'b1;
            out_pc    = pc_q;
            out_inst  = inst_data;
        end
    end

    assign buf_pop   = out_valid && out_ready && !bypass;
    assign can_fetch = !buf_full || buf_pop;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
        buf_push  = 1'b0;
        buf_flush = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_valid && !halt_req) begin
                    // The word fetched this cycle is dropped along with the buffer.
                    buf_flush = 1'b1;
                    if (redirect_ok) begin
                        pc_d = redirect_pc;
                    end else begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end
                end else if (pc_q > LAST_PC) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end else begin
                    if (bypass && out_ready) begin
                        pc_d = pc_q + PC_W'(4);
                    end else if (can_fetch) begin
                        buf_push = 1'b1;
                        pc_d     = pc_q + PC_W'(4);
                    end
                    if (halt_req) state_d = HALT;
                end
            end
            HALT: begin
                if (redirect_valid && !halt_req) begin
                    buf_flush = 1'b1;
                    if (redirect_ok) begin
                        pc_d    = redirect_pc;
                        fault_d = 1'b0;
                        state_d = RUN;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (buf_push),
        .push_data (fetch_word),
        .pop       (buf_pop),
        .flush     (buf_flush),
        .full      (buf_full),
        .empty     (buf_empty),
        .head      (buf_head)
    );

    assign inst_addr = pc_q;
    assign halted    = (state_q == HALT);
    assign fault     = fault_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a 132-byte combinational instruction memory model.
module tb_inst_fetch_ctrl;
    import imem_fetch_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [PC_W-1:0]   inst_addr;
    logic [INST_W-1:0] inst_data;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              halt_req;
    logic              halted;
    logic              fault;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a <= 64'd128) ? {16'hC0DE, a[15:0]} : NOP;
    endfunction

    assign inst_data = mem_word(inst_addr);

    inst_fetch_ctrl #(
        .RESET_PC  (64'h0),
        .MEM_BYTES (132),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .inst_addr      (inst_addr),
        .inst_data      (inst_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .fault          (fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Head entry must be valid with the given pc and the memory word at that pc.
    task automatic chk_head(input string tag, input logic [63:0] pc);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".inst"}, 64'(out_inst), 64'(mem_word(pc)));
    endtask

    initial begin
        reset_n        = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;

        #3;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.addr", inst_addr, 64'h0);
        chk("rst.pc", out_pc, 64'h0);
        chk("rst.inst", 64'(out_inst), 64'h0);
        chk("rst.halted", 64'(halted), 64'd0);
        chk("rst.fault", 64'(fault), 64'd0);
        #9 reset_n = 1'b1;

        // BOOT cycle ends, first RUN cycle has nothing buffered yet.
        step();
        chk("boot.valid", 64'(out_valid), 64'd0);
        chk("boot.addr", inst_addr, 64'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_head("stream", 64'(4 * k));
        end
        chk("stream.addr", inst_addr, 64'h10);

        // Stall: buffer fills to {0x0C, 0x10} and the fetch address holds at 0x14.
        out_ready = 1'b0;
        repeat (5) step();
        chk_head("stall", 64'h0C);
        chk("stall.addr", inst_addr, 64'h14);
        out_ready = 1'b1;
        step();
        chk_head("drain0", 64'h10);
        step();
        chk_head("drain1", 64'h14);
        step();
        chk_head("drain2", 64'h18);
        chk("drain.addr", inst_addr, 64'h20);

        // Redirect with a full buffer {0x18, 0x1C}.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2C;
        step();
        redirect_valid = 1'b0;
        chk("redir.valid", 64'(out_valid), 64'd0);
        chk("redir.addr", inst_addr, 64'h2C);
        step();
        chk_head("redir.t2", 64'h2C);
        step();
        chk_head("redir.t3", 64'h30);

        // Misaligned redirect: fault, halt, pc holds at 0x34.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2E;
        step();
        redirect_valid = 1'b0;
        chk("mis.fault", 64'(fault), 64'd1);
        chk("mis.halted", 64'(halted), 64'd1);
        chk("mis.valid", 64'(out_valid), 64'd0);
        chk("mis.addr", inst_addr, 64'h34);
        repeat (2) step();
        chk("mis.hold.valid", 64'(out_valid), 64'd0);
        chk("mis.hold.addr", inst_addr, 64'h34);

        // Legal redirect out of HALT.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h04;
        step();
        redirect_valid = 1'b0;
        chk("rec.fault", 64'(fault), 64'd0);
        chk("rec.halted", 64'(halted), 64'd0);
        chk("rec.valid", 64'(out_valid), 64'd0);
        step();
        chk_head("rec.head", 64'h04);

        // Run off the end of memory: 0x7C and 0x80 delivered, 0x84 faults.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h7C;
        step();
        redirect_valid = 1'b0;
        step();
        chk_head("end0", 64'h7C);
        step();
        chk_head("end1", 64'h80);
        chk("end1.halted", 64'(halted), 64'd0);
        step();
        chk("end.valid", 64'(out_valid), 64'd0);
        chk("end.fault", 64'(fault), 64'd1);
        chk("end.halted", 64'(halted), 64'd1);
        chk("end.addr", inst_addr, 64'h84);

        // Back to RUN, then halt_req together with a redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h10;
        step();
        redirect_valid = 1'b0;
        step();
        chk_head("pre.halt", 64'h10);
        halt_req       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        step();
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        chk("hr.halted", 64'(halted), 64'd1);
        chk("hr.fault", 64'(fault), 64'd0);
        chk_head("hr.head", 64'h14);
        chk("hr.addr", inst_addr, 64'h18);
        step();
        chk("hr.drain.valid", 64'(out_valid), 64'd0);
        chk("hr.drain.addr", inst_addr, 64'h18);
        chk("hr.drain.halted", 64'(halted), 64'd1);

        // Restart at 0, then reset mid-stream.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        step();
        redirect_valid = 1'b0;
        step();
        chk_head("rs0", 64'h0);
        step();
        chk_head("rs1", 64'h4);
        chk("rs1.addr", inst_addr, 64'h8);
        reset_n = 1'b0;
        #1;
        chk("arst.valid", 64'(out_valid), 64'd0);
        chk("arst.addr", inst_addr, 64'h0);
        chk("arst.halted", 64'(halted), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("arst.boot.valid", 64'(out_valid), 64'd0);
        step();
        chk_head("arst.first", 64'h0);
        step();
        chk_head("arst.second", 64'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
